and_gate_checker: RTL and testbench
===================================

# and_gate_checker

Exhaustive pattern generator and response checker for the 4-input AND function. Drives all 16 combinations onto `in1..in4`, waits a programmable settle time, then compares the returned `dut_out` against the expected AND of the vector. Reports pass/fail, the mismatch count and the first failing vector. Sits opposite `and_gate_func` as an on-chip BIST/checker, so the self-check runs in silicon or FPGA without a simulation bench.

## Interface
- `SETTLE_CYCLES`, default 2: cycles between driving a vector and sampling `dut_out`. Legal range 1..255.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a sweep. Sampled only in IDLE or DONE.
- `in1`, `in2`, `in3`, `in4`, output, 1 each: registered stimulus bits, equal to `vec[0]..vec[3]`.
- `dut_out`, input, 1: response from the function under test.
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: level; high in DONE until the next accepted `start` or reset.
- `pass`, output, 1: valid while `done` is high; 1 when `fail_count == 0`.
- `fail_count`, output, 5: number of mismatching vectors, 0..16.
- `first_fail_vec`, output, 4: vector index of the first mismatch; 0 if there was none.

## Operation
- Reset values: all outputs are 0; state is IDLE; `vec`, settle counter and `first_fail_seen` are 0.
- States:
  - IDLE: `start` moves to DRIVE with `vec = 0`. It also clears `fail_count`, `first_fail_vec` and `first_fail_seen`.
  - DRIVE: one cycle. `in1..in4` take the current `vec`. The settle counter loads `SETTLE_CYCLES-1`. Next state is SETTLE.
  - SETTLE: counts down and moves to CHECK when the counter is 0.
  - CHECK: one cycle. Samples `dut_out` and compares it with `expected = &vec`.
    - On mismatch, `fail_count` increments.
    - If `first_fail_seen` is 0, `first_fail_vec` takes `vec` and `first_fail_seen` is set.
    - If `vec == 15`, next state is DONE. Otherwise `vec` increments and the next state is DRIVE.
  - DONE: `done` is 1 and `busy` is 0. `start` behaves as it does in IDLE, restarting the sweep and clearing the results.
- `busy` is high in DRIVE, SETTLE and CHECK.
- `start` is ignored while `busy` is high.
- `in1..in4` hold their last value in DONE and return to 0 only on reset.
- `fail_count` cannot exceed 16, so no saturation logic is needed.
- An `X` or `Z` on `dut_out` is not checked in RTL. It counts as whatever value the sampling flop resolves to.
- Reset asserted mid-sweep returns immediately to IDLE with all outputs 0. No partial results are retained.

## Timing
- Let `start` be sampled high at edge k.
  - `busy` rises after edge k.
  - `in1..in4 = 0000` after edge k+1, the DRIVE cycle.
- Per vector: 1 DRIVE + `SETTLE_CYCLES` SETTLE + 1 CHECK = `SETTLE_CYCLES+2` cycles.
- `dut_out` is sampled `SETTLE_CYCLES+1` edges after the vector appears on `in1..in4`.
- A full sweep takes `16*(SETTLE_CYCLES+2)` cycles from the first DRIVE. `done` rises on the edge after the vector-15 CHECK.
- `fail_count` and `first_fail_vec` update on the CHECK edge. Both are stable once `done` is 1.
- `start` held high continuously restarts a new sweep on the cycle after DONE is entered.

## Configuration
- `AND_CHK_STOP_ON_FAIL_EN`
  - Defined: the first mismatch in CHECK moves straight to DONE. `fail_count` is then 1, `first_fail_vec` is the failing index, and `in1..in4` hold the failing vector for debug.
  - Undefined (default): the sweep always covers all 16 vectors.

## Test plan
- Correct AND model on `dut_out`, `SETTLE_CYCLES=2`, pulse `start` -> `busy` is high for 64 cycles, then `done=1`, `pass=1`, `fail_count=0`, `first_fail_vec=0`.
- `dut_out` tied to 0 -> `pass=0`, `fail_count=1`, `first_fail_vec=15`.
- `dut_out` tied to 1 -> `fail_count=15`, `first_fail_vec=0`.
- OR model (`in1|in2|in3|in4`), with the macro undefined -> `fail_count=14`, `first_fail_vec=1`. With `AND_CHK_STOP_ON_FAIL_EN` defined -> `fail_count=1`, `first_fail_vec=1`, `in1..in4 = 1,0,0,0` held.
- `rst_n` pulsed low during vector 7 -> all outputs are 0 asynchronously, state is IDLE. A new `start` runs a clean 64-cycle sweep with `pass=1`.
- `start` re-pulsed while `busy` is high -> ignored; sweep length stays 64 cycles. `start` pulsed in DONE -> `done` drops, results clear, and a new sweep begins.

Source files
------------

// File: rtl/and_gate_checker.sv
// Exhaustive BIST driver/checker for a 4-input AND function under test.
// Optional: AND_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module and_gate_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_count,
  output logic [3:0] first_fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] stim_q, stim_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] fc_q, fc_d;
  logic [3:0] ffv_q, ffv_d;
  logic       seen_q, seen_d;

  logic       accept;
  logic       mismatch;
  logic       stop_hit;
  logic       last_vec;

  assign accept   = start &&
                    (state_q == S_IDLE || state_q == S_DONE);
  assign mismatch = (dut_out != (&vec_q));
  assign last_vec = (vec_q == 4'hf);

`ifdef AND_CHK_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (last_vec || stop_hit) state_d = S_DONE;
        else                      state_d = S_DRIVE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      stim_q <= '0;
      cnt_q  <= '0;
      fc_q   <= '0;
      ffv_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      stim_q <= stim_d;
      cnt_q  <= cnt_d;
      fc_q   <= fc_d;
      ffv_q  <= ffv_d;
      seen_q <= seen_d;
    end
  end

  always_comb begin
    vec_d  = vec_q;
    stim_d = stim_q;
    cnt_d  = cnt_q;
    fc_d   = fc_q;
    ffv_d  = ffv_q;
    seen_d = seen_q;
    if (accept) begin
      vec_d  = '0;
      fc_d   = '0;
      ffv_d  = '0;
      seen_d = 1'b0;
    end
    unique case (state_q)
      S_DRIVE: begin
        stim_d = vec_q;
        cnt_d  = CNT_LOAD;
      end
      S_SETTLE: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
      end
      S_CHECK: begin
        if (mismatch) begin
          fc_d = fc_q + 5'd1;
          if (!seen_q) begin
            ffv_d  = vec_q;
            seen_d = 1'b1;
          end
        end
        // vec holds on the final/stopping vector
        if (!(last_vec || stop_hit)) vec_d = vec_q + 4'd1;
      end
      default: begin
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == S_DRIVE),
      (state_q == S_SETTLE),
      (state_q == S_CHECK): busy = 1'b1;
      (state_q == S_DONE):  done = 1'b1;
      default: begin
      end
    endcase
    pass = done && (fc_q == 5'd0);
  end

  assign in1            = stim_q[0];
  assign in2            = stim_q[1];
  assign in3            = stim_q[2];
  assign in4            = stim_q[3];
  assign fail_count     = fc_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_and_gate_checker.sv
// Bench for and_gate_checker: sweep-level model plus directed sweeps.
// Functions under test: AND, stuck-0, stuck-1 and OR.
module tb_and_gate_checker;

  localparam int S = 2;
  localparam int L = S + 2;
`ifdef AND_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dut_out;
  logic       in1, in2, in3, in4;
  logic       busy, done, pass;
  logic [4:0] fail_count;
  logic [3:0] first_fail_vec;
  logic [3:0] ins;

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  and_gate_checker #(.SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .dut_out        (dut_out),
    .in1            (in1),
    .in2            (in2),
    .in3            (in3),
    .in4            (in4),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_vec (first_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ins = {in4, in3, in2, in1};

  function automatic bit resp(int md, logic [3:0] v);
    case (md)
      0:       return &v;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return |v;
    endcase
  endfunction

  assign dut_out = resp(mode, ins);

  function automatic bit mis_v(int v);
    logic [3:0] vv;
    vv = 4'(v);
    return resp(mode, vv) != (v == 15);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Sweep model: c counts edges since start was accepted
  bit         m_run, m_done, m_seen;
  int         m_c, m_fc;
  logic [3:0] m_in, m_ffv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 0; m_done <= 0; m_seen <= 0;
      m_c    <= 0; m_fc   <= 0;
      m_in   <= 0; m_ffv  <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1; m_done <= 0; m_seen <= 0;
        m_c   <= 0; m_fc   <= 0; m_ffv  <= 0;
      end
    end else begin
      m_c <= m_c + 1;
      if ((m_c + 1) % L == 1) m_in <= 4'(m_c / L);
      if ((m_c + 1) % L == 0) begin
        if (mis_v((m_c + 1) / L - 1)) begin
          m_fc <= m_fc + 1;
          if (!m_seen) begin
            m_ffv  <= 4'((m_c + 1) / L - 1);
            m_seen <= 1;
          end
        end
        if (((m_c + 1) / L - 1) == 15 ||
            (STOP && mis_v((m_c + 1) / L - 1))) begin
          m_run  <= 0;
          m_done <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("pass", pass, m_done && m_fc == 0);
      chk("fail_count", fail_count, m_fc);
      chk("first_fail_vec", first_fail_vec, m_ffv);
      chk("stim", ins, m_in);
    end
  end

  task automatic sweep(int md, int efc, int effv, int elen, bit rep);
    int n;
    mode = md;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("start_done_low", done, 0);
        chk("start_fc_clear", fail_count, 0);
      end
      if (busy) n++;
      if (rep && (n == 20 || n == 40)) start = 1'b1;
      else start = 1'b0;
      if (done) break;
    end
    chk("sweep_done", done, 1);
    chk("sweep_len", n, elen);
    chk("lit_fail_count", fail_count, efc);
    chk("lit_first_fail", first_fail_vec, effv);
    chk("lit_pass", pass, efc == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fc", fail_count, 0);
    chk("rst_ffv", first_fail_vec, 0);
    chk("rst_stim", ins, 0);
    #2 rst_n = 1'b1;

    sweep(0, 0, 0, 16 * L, 1'b1);
    sweep(1, 1, 15, 16 * L, 1'b0);
    sweep(2, STOP ? 1 : 15, 0, STOP ? L : 16 * L, 1'b0);
    sweep(3, STOP ? 1 : 14, 1, STOP ? 2 * L : 16 * L, 1'b0);
    if (STOP) chk("stop_hold_stim", ins, 4'b0001);
    else      chk("done_hold_stim", ins, 4'hf);

    // Held start: restart right after DONE
    mode = 0;
    @(posedge clk); #1 start = 1'b1;
    repeat (16 * L + 6) @(posedge clk);
    #1 start = 1'b0;
    repeat (16 * L + 4) @(negedge clk);
    chk("held_done", done, 1);

    // Reset during vector 7
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(negedge clk);
    chk("vec7_stim", ins, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_fc", fail_count, 0);
    chk("arst_ffv", first_fail_vec, 0);
    chk("arst_stim", ins, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    sweep(0, 0, 0, 16 * L, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
